// File: rtl/counter_chk.sv
// counter_chk: tracks a sampled counter stream and flags samples that break
// the programmed up/down/step/bounds sequence.
// Optional feature macro: COUNTER_CHK_RESYNC_EN -- when defined, a mismatch
// re-seeds the prediction from the observed sample and err is a one-cycle
// pulse; when undefined, the FAULT state is sticky until clr or rst.
module counter_chk (
   input  logic        clk,
   input  logic        rst,
   input  logic [35:0] cnt,
   input  logic        ena,
   input  logic        updown,
   input  logic [8:0]  step,
   input  logic [35:0] MIN_COUNT,
   input  logic [35:0] MAX_COUNT,
   input  logic        clr,
   output logic [35:0] expected,
   output logic        locked,
   output logic        err,
   output logic [15:0] err_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [35:0] expected_q, expected_d;
   logic        locked_q, locked_d;
   logic        err_q, err_d;
   logic [15:0] err_cnt_q, err_cnt_d;

   logic [35:0] nxt_cnt;
   logic [35:0] nxt_exp;
   logic [15:0] err_cnt_inc;

   // Successor of v under the current direction, step and bounds. Sums are
   // formed at 37 bits so values near the top of the 36-bit range wrap to
   // the opposite bound instead of overflowing.
   function automatic logic [35:0] next_val(
      input logic [35:0] v,
      input logic        up,
      input logic [8:0]  stp,
      input logic [35:0] mn,
      input logic [35:0] mx
   );
      logic [36:0] sum;
      logic [36:0] floor_v;
      sum     = {1'b0, v}  + {28'b0, stp};
      floor_v = {1'b0, mn} + {28'b0, stp};
      if (up)
         return (sum <= {1'b0, mx}) ? sum[35:0] : mn;
      else
         return ({1'b0, v} >= floor_v) ? (v - {27'b0, stp}) : mx;
   endfunction

   // Predictions from the live sample and from the held expectation.
   always_comb begin
      nxt_cnt     = next_val(cnt, updown, step, MIN_COUNT, MAX_COUNT);
      nxt_exp     = next_val(expected_q, updown, step, MIN_COUNT, MAX_COUNT);
      err_cnt_inc = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 16'd1;
   end

   // Next-state logic; clr overrides any sample in the same cycle.
   always_comb begin
      state_d    = state_q;
      expected_d = expected_q;
      locked_d   = locked_q;
      err_d      = err_q;
      err_cnt_d  = err_cnt_q;

      if (clr) begin
         state_d   = IDLE;
         locked_d  = 1'b0;
         err_d     = 1'b0;
         err_cnt_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ena) begin
                  expected_d = nxt_cnt;
                  locked_d   = 1'b1;
                  state_d    = TRACK;
               end
            end
`ifdef COUNTER_CHK_RESYNC_EN
            // FAULT only lasts one cycle, so a sample arriving during it is
            // checked exactly like a TRACK sample; back-to-back mismatches
            // each count.
            TRACK, FAULT: begin
               err_d   = 1'b0;
               state_d = TRACK;
               if (ena) begin
                  if (cnt == expected_q) begin
                     expected_d = nxt_exp;
                  end else begin
                     err_d      = 1'b1;
                     err_cnt_d  = err_cnt_inc;
                     expected_d = nxt_cnt;
                     state_d    = FAULT;
                  end
               end
            end
`else
            TRACK: begin
               if (ena) begin
                  if (cnt == expected_q) begin
                     expected_d = nxt_exp;
                  end else begin
                     err_d     = 1'b1;
                     err_cnt_d = err_cnt_inc;
                     state_d   = FAULT;
                  end
               end
            end
            FAULT: begin
               // sticky: samples ignored until clr or rst
            end
`endif
            default: begin
               state_d  = IDLE;
               locked_d = 1'b0;
               err_d    = 1'b0;
            end
         endcase
      end
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         expected_q <= '0;
         locked_q   <= 1'b0;
         err_q      <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         expected_q <= expected_d;
         locked_q   <= locked_d;
         err_q      <= err_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign expected = expected_q;
   assign locked   = locked_q;
   assign err      = err_q;
   assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_counter_chk.sv
// Directed-vector bench for counter_chk (honours COUNTER_CHK_RESYNC_EN).
module tb_counter_chk;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [35:0] cnt = '0;
   logic        ena = 1'b0;
   logic        updown = 1'b1;
   logic [8:0]  step = '0;
   logic [35:0] min_count = '0;
   logic [35:0] max_count = '0;
   logic        clr = 1'b0;
   logic [35:0] expected;
   logic        locked;
   logic        err;
   logic [15:0] err_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [35:0] ALL1 = 36'hF_FFFF_FFFF;

`ifdef COUNTER_CHK_RESYNC_EN
   localparam bit RS = 1'b1;
`else
   localparam bit RS = 1'b0;
`endif

   counter_chk dut (
      .clk       (clk),
      .rst       (rst),
      .cnt       (cnt),
      .ena       (ena),
      .updown    (updown),
      .step      (step),
      .MIN_COUNT (min_count),
      .MAX_COUNT (max_count),
      .clr       (clr),
      .expected  (expected),
      .locked    (locked),
      .err       (err),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ena;
      logic        clr;
      logic        up;
      logic [8:0]  step;
      logic [35:0] mn;
      logic [35:0] mx;
      logic [35:0] cnt;
      logic        chk_exp;
      logic [35:0] x_exp;
      logic        x_locked;
      logic        x_err;
      logic [15:0] x_err_cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic e, input logic c, input logic up,
                      input logic [8:0] st, input logic [35:0] mn,
                      input logic [35:0] mx, input logic [35:0] cv,
                      input logic ce, input logic [35:0] xe,
                      input logic xl, input logic xr, input logic [15:0] xc);
      vec_t v;
      v.ena = e; v.clr = c; v.up = up; v.step = st; v.mn = mn; v.mx = mx;
      v.cnt = cv; v.chk_exp = ce; v.x_exp = xe; v.x_locked = xl;
      v.x_err = xr; v.x_err_cnt = xc;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [35:0] act,
                        input logic [35:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Drive one row, clock it in, and compare the registered outputs.
   task automatic apply(input vec_t v, input string tag);
      ena = v.ena; clr = v.clr; updown = v.up; step = v.step;
      min_count = v.mn; max_count = v.mx; cnt = v.cnt;
      @(posedge clk);
      #1;
      if (v.chk_exp) check({tag, " expected"}, expected, v.x_exp);
      check({tag, " locked"}, {35'b0, locked}, {35'b0, v.x_locked});
      check({tag, " err"}, {35'b0, err}, {35'b0, v.x_err});
      check({tag, " err_cnt"}, {20'b0, err_cnt}, {20'b0, v.x_err_cnt});
   endtask

   initial begin
      // up, step 3, bounds 0..10
      add(1,0,1,3,0,10, 0, 1, 3,1,0,0);
      add(1,0,1,3,0,10, 3, 1, 6,1,0,0);
      add(1,0,1,3,0,10, 6, 1, 9,1,0,0);
      add(1,0,1,3,0,10, 9, 1, 0,1,0,0);
      add(1,0,1,3,0,10, 0, 1, 3,1,0,0);
      add(1,0,1,3,0,10, 3, 1, 6,1,0,0);
      add(0,1,1,3,0,10, 0, 0, 0,0,0,0);
      // down, step 4, bounds 2..20, with an idle cycle
      add(1,0,0,4,2,20,20, 1,16,1,0,0);
      add(0,0,0,4,2,20,99, 1,16,1,0,0);
      add(1,0,0,4,2,20,16, 1,12,1,0,0);
      add(1,0,0,4,2,20,12, 1, 8,1,0,0);
      add(1,0,0,4,2,20, 8, 1, 4,1,0,0);
      add(1,0,0,4,2,20, 4, 1,20,1,0,0);
      add(1,0,0,4,2,20,20, 1,16,1,0,0);
      add(0,1,0,4,2,20, 0, 0, 0,0,0,0);
      // mismatch on sample 8
      add(1,0,1,1,0,100,5, 1,6,1,0,0);
      add(1,0,1,1,0,100,6, 1,7,1,0,0);
      add(1,0,1,1,0,100,8, 1, RS ? 36'd9 : 36'd7, 1,1,1);
      add(0,0,1,1,0,100,0, 1, RS ? 36'd9 : 36'd7, 1, !RS, 1);
      add(1,0,1,1,0,100,9, 1, RS ? 36'd10 : 36'd7, 1, !RS, 1);
      // ena and clr together: clr wins, sample ignored, next sample re-seeds
      add(1,1,1,1,0,100,50, 0, 0,0,0,0);
      add(1,0,1,1,0,100,20, 1,21,1,0,0);
      // step change between samples applies to the next prediction only
      add(0,0,1,5,0,100,77, 1,21,1,0,0);
      add(1,0,1,5,0,100,21, 1,26,1,0,0);
      // up boundary: exactly MAX, then past MAX wraps to MIN
      add(1,0,1,4,1,30,26, 1,30,1,0,0);
      add(1,0,1,4,1,30,30, 1, 1,1,0,0);
      add(0,1,1,4,1,30, 0, 0, 0,0,0,0);
      // 37-bit arithmetic near the top of the range
      add(1,0,1,9'h1FF,5,ALL1,36'hF_FFFF_FFF0, 1,5,1,0,0);
      add(1,0,0,9'h1FF,0,ALL1,5, 1,ALL1,1,0,0);
      add(1,0,0,9'h1FF,36'hF_FFFF_FF00,ALL1,ALL1, 1,ALL1,1,0,0);
      add(0,1,0,4,10,50,0, 0, 0,0,0,0);
      // down boundary: v == MIN+step still steps, below it wraps to MAX
      add(1,0,0,4,10,50,14, 1,10,1,0,0);
      add(1,0,0,4,10,50,10, 1,50,1,0,0);

      // asynchronous reset at time 1, before any clock edge
      #1 rst = 1'b0;
      #1;
      check("rst expected", expected, 36'h0);
      check("rst locked", {35'b0, locked}, 36'h0);
      check("rst err", {35'b0, err}, 36'h0);
      check("rst err_cnt", {20'b0, err_cnt}, 36'h0);
      @(posedge clk);
      #1 rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++)
         apply(vecs[i], $sformatf("row%0d", i));

      // reset pulsed mid-TRACK, checked between clock edges
      #1 rst = 1'b0;
      #1;
      check("midrst expected", expected, 36'h0);
      check("midrst locked", {35'b0, locked}, 36'h0);
      check("midrst err", {35'b0, err}, 36'h0);
      check("midrst err_cnt", {20'b0, err_cnt}, 36'h0);
      @(posedge clk);
      #1 rst = 1'b1;
      begin
         vec_t v;
         v.ena = 1; v.clr = 0; v.up = 1; v.step = 1; v.mn = 0; v.mx = 100;
         v.cnt = 40; v.chk_exp = 1; v.x_exp = 41; v.x_locked = 1;
         v.x_err = 0; v.x_err_cnt = 0;
         apply(v, "reseed");
      end

`ifdef COUNTER_CHK_RESYNC_EN
      // 65536 back-to-back mismatches: err_cnt must stick at FFFF
      begin
         vec_t v;
         v.ena = 0; v.clr = 1; v.up = 1; v.step = 1; v.mn = 0; v.mx = 1000;
         v.cnt = 0; v.chk_exp = 0; v.x_exp = 0; v.x_locked = 0;
         v.x_err = 0; v.x_err_cnt = 0;
         apply(v, "sat clr");
         v.ena = 1; v.clr = 0; v.chk_exp = 1; v.x_exp = 1; v.x_locked = 1;
         apply(v, "sat seed");
      end
      ena = 1'b1; clr = 1'b0; cnt = 36'd0;
      for (int i = 0; i < 65536; i++) begin
         @(posedge clk);
         #1;
         if (i == 0) check("sat first", {20'b0, err_cnt}, 36'h1);
         if (i == 65534) check("sat reach", {20'b0, err_cnt}, 36'hFFFF);
      end
      check("sat hold", {20'b0, err_cnt}, 36'hFFFF);
      check("sat err", {35'b0, err}, 36'h1);
      ena = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/counter_chk.md
COUNTER_CHK -- requirements
Module: counter_chk

Interface
REQ-001 The block SHALL expose these ports: clk, input, 1, single clock; all state updates on the rising edge.
REQ-002 The block SHALL expose these ports: rst, input, 1, asynchronous active-low reset.
REQ-003 The block SHALL expose these ports: cnt, input, 36, observed count sample.
REQ-004 The block SHALL expose these ports: ena, input, 1, cnt sample valid this cycle.
REQ-005 The block SHALL expose these ports: updown, input, 1, 1 = counting up, 0 = counting down.
REQ-006 The block SHALL expose these ports: step, input, 9, unsigned increment per valid sample.
REQ-007 The block SHALL expose these ports: MIN_COUNT / MAX_COUNT, input, 36 each, inclusive count bounds, MIN_COUNT <= MAX_COUNT.
REQ-008 The block SHALL expose these ports: clr, input, 1, synchronous clear of error state and error counter.
REQ-009 The block SHALL expose these ports: expected, output, 36, predicted value of the next valid cnt.
REQ-010 The block SHALL expose these ports: locked, output, 1, the checker holds a valid prediction.
REQ-011 The block SHALL expose these ports: err, output, 1, the mismatch flag.
REQ-012 The block SHALL expose these ports: err_cnt, output, 16, saturating mismatch count.

Function
REQ-013 The FSM SHALL have three states: IDLE, TRACK and FAULT.
REQ-014 The block SHALL compute the next value from a value v as follows:
- up: v+step if v+step <= MAX_COUNT, else MIN_COUNT.
- down: v-step if v >= MIN_COUNT+step, else MAX_COUNT.
- All sums SHALL be evaluated at 37 bits, so there is no 36-bit overflow.
REQ-015 In IDLE, a cycle with ena=1 SHALL do all of the following:
- load expected with next(cnt);
- set locked=1;
- move to TRACK.
No comparison is made on this cycle.
REQ-016 In TRACK, a cycle with ena=1 and cnt==expected SHALL load expected with next(expected) and stay in TRACK.
REQ-017 In TRACK, a cycle with ena=1 and cnt!=expected SHALL do all of the following:
- set err=1 on the following edge;
- increment err_cnt, saturating at 16'hFFFF;
- move to FAULT.
REQ-018 A cycle with ena=0 SHALL hold expected and the state unchanged.
REQ-019 Updown, step and the bounds SHALL be sampled on the same edge as cnt.
REQ-020 A parameter change between samples SHALL take effect on the next prediction only.
REQ-021 In FAULT, err SHALL remain 1 and locked SHALL remain 1.
REQ-022 Clr=1 SHALL force IDLE, err=0, err_cnt=0 and locked=0 on the next edge.
REQ-023 Clr SHALL have priority over ena in the same cycle.
REQ-024 Outputs SHALL be registered, with a latency of one clock from the sampled cnt to expected, err and err_cnt.

Reset
REQ-025 While rst=0, the block SHALL immediately force the following, independent of clk:
- state=IDLE;
- expected=36'h0;
- locked=0;
- err=0;
- err_cnt=16'h0.
REQ-026 A reset asserted mid-sequence SHALL discard the prediction, so that the first valid sample after rst deassertion re-seeds the checker.

Configuration
REQ-027 With COUNTER_CHK_RESYNC_EN defined, FAULT SHALL last exactly one cycle, and expected SHALL be re-seeded with next(observed cnt) on the mismatching sample.
REQ-028 With COUNTER_CHK_RESYNC_EN defined, err SHALL be a one-cycle pulse per mismatch, and the block SHALL then return to TRACK.
REQ-029 Without COUNTER_CHK_RESYNC_EN, FAULT SHALL be sticky, err SHALL stay high, and further samples SHALL be ignored until clr or rst.

Verification
REQ-030 The bench SHALL cover each of these scenarios:
- Up count, step=3, MIN=0, MAX=10, samples 0,3,6,9,0,3 -> err=0 throughout, locked=1 from the cycle after the first sample.
- Down count, step=4, MIN=2, MAX=20, samples 20,16,12,8,4,20 -> no err; expected=16 after sample 20.
- Up count, step=1, samples 5,6,8 -> err=1 one cycle after sample 8 and err_cnt=1. With RESYNC_EN: expected=9 and err returns to 0. Without it: err stays 1.
- Force 65536 mismatches with RESYNC_EN -> err_cnt saturates at 16'hFFFF and does not wrap.
- rst pulsed low mid-TRACK -> all outputs zero asynchronously; after release, the next sample re-seeds with no err.
- ena and clr high together in FAULT -> IDLE, err=0, err_cnt=0, and the sample is ignored.
